// File: rtl/axi_slave_mem.sv
// AXI3-style slave memory: word-addressed SRAM behind independent read and
// write burst engines. INCR bursts of 32-bit beats only; anything else is
// answered with SLVERR and never touches the array.
module axi_slave_mem #(
    parameter int ADDR_LG2   = 10,
    parameter int RD_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  awid_i,
    input  logic [31:0] awaddr_i,
    input  logic [3:0]  awlen_i,
    input  logic [2:0]  awsize_i,
    input  logic [1:0]  awburst_i,
    input  logic        awvalid_i,
    output logic        awready_o,
    input  logic [3:0]  wid_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    input  logic        wlast_i,
    input  logic        wvalid_i,
    output logic        wready_o,
    output logic [3:0]  bid_o,
    output logic [1:0]  bresp_o,
    output logic        bvalid_o,
    input  logic        bready_i,
    input  logic [3:0]  arid_i,
    input  logic [31:0] araddr_i,
    input  logic [3:0]  arlen_i,
    input  logic [2:0]  arsize_i,
    input  logic [1:0]  arburst_i,
    input  logic        arvalid_i,
    output logic        arready_o,
    output logic [3:0]  rid_o,
    output logic [31:0] rdata_o,
    output logic [1:0]  rresp_o,
    output logic        rlast_o,
    output logic        rvalid_o,
    input  logic        rready_i
);
    localparam int DEPTH = 1 << ADDR_LG2;
    localparam int IW    = ADDR_LG2;
    localparam int IW1   = ADDR_LG2 + 1;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;

    logic [31:0] mem [DEPTH];

    // A burst is legal when it is a word-aligned INCR of 4-byte beats whose
    // last word still lies inside the array (so the index never wraps).
    function automatic logic burst_legal(input logic [31:0] a, input logic [3:0] len,
                                         input logic [2:0] sz, input logic [1:0] bt);
        logic [IW:0] endw;
        endw = {1'b0, a[IW+1:2]} + IW1'(len);
        return (sz == 3'b010) && (bt == 2'b01) && (a[1:0] == 2'b00) &&
               (a[31:IW+2] == '0) && !endw[IW];
    endfunction

    // ---------------- write channel ----------------
    wstate_t       wstate_q, wstate_d;
    logic [3:0]    wid_q, wlen_q, wbeat_q;
    logic [IW-1:0] widx_q;
    logic          willegal_q, wbad_q;
    logic          aw_hs, w_hs;

    assign aw_hs   = awvalid_i & awready_o;
    assign w_hs    = wvalid_i & wready_o;
    assign bid_o   = wid_q;
    assign bresp_o = (willegal_q | wbad_q) ? 2'b10 : 2'b00;

    // Write FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) wstate_q <= W_IDLE;
        else        wstate_q <= wstate_d;
    end

    // Write FSM next state and channel handshake outputs.
    always_comb begin
        wstate_d  = wstate_q;
        awready_o = 1'b0;
        wready_o  = 1'b0;
        bvalid_o  = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                awready_o = 1'b1;
                if (awvalid_i) wstate_d = W_DATA;
            end
            W_DATA: begin
                wready_o = 1'b1;
                // The beat counter, not wlast, decides where the burst ends.
                if (wvalid_i && wbeat_q == wlen_q) wstate_d = W_RESP;
            end
            W_RESP: begin
                bvalid_o = 1'b1;
                if (bready_i) wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // Write burst bookkeeping: latched AW fields, beat/index counters, error flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wid_q      <= '0;
            wlen_q     <= '0;
            wbeat_q    <= '0;
            widx_q     <= '0;
            willegal_q <= 1'b0;
            wbad_q     <= 1'b0;
        end else begin
            if (aw_hs) begin
                wid_q      <= awid_i;
                wlen_q     <= awlen_i;
                wbeat_q    <= '0;
                widx_q     <= awaddr_i[IW+1:2];
                willegal_q <= !burst_legal(awaddr_i, awlen_i, awsize_i, awburst_i);
                wbad_q     <= 1'b0;
            end
            if (w_hs) begin
                wbeat_q <= wbeat_q + 4'd1;
                widx_q  <= widx_q + 1'b1;
                if ((wlast_i != (wbeat_q == wlen_q)) || (wid_i != wid_q)) wbad_q <= 1'b1;
            end
        end
    end

    // Byte-masked array write; memory contents survive reset.
    always_ff @(posedge clk) begin
        if (rst_n && w_hs && !willegal_q) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_i[b]) mem[widx_q][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    rstate_t       rstate_q, rstate_d;
    logic [3:0]    rid_q, rlen_q, rbeat_q, rcnt_q;
    logic [IW-1:0] ridx_q;
    logic          rerr_q;
    logic [31:0]   rdata_q;
    logic          ar_hs, r_hs, rd_load;

    assign ar_hs   = arvalid_i & arready_o;
    assign r_hs    = rvalid_o & rready_i;
    assign rid_o   = rid_q;
    assign rdata_o = rdata_q;
    assign rresp_o = rerr_q ? 2'b10 : 2'b00;
    // Fetch a word at the end of the latency wait, and again on every
    // non-final handshake so the next beat follows with no bubble.
    assign rd_load = ((rstate_q == R_WAIT) && (rcnt_q == 4'd0)) ||
                     (r_hs && (rbeat_q != rlen_q));

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) rstate_q <= R_IDLE;
        else        rstate_q <= rstate_d;
    end

    // Read FSM next state and channel handshake outputs.
    always_comb begin
        rstate_d  = rstate_q;
        arready_o = 1'b0;
        rvalid_o  = 1'b0;
        rlast_o   = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                arready_o = 1'b1;
                if (arvalid_i) rstate_d = R_WAIT;
            end
            R_WAIT: begin
                if (rcnt_q == 4'd0) rstate_d = R_DATA;
            end
            R_DATA: begin
                rvalid_o = 1'b1;
                rlast_o  = (rbeat_q == rlen_q);
                if (rready_i && rbeat_q == rlen_q) rstate_d = R_IDLE;
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    // Read burst bookkeeping and the beat data register; the array is sampled
    // before any same-edge write lands, giving read-first behaviour.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rid_q   <= '0;
            rlen_q  <= '0;
            rbeat_q <= '0;
            rcnt_q  <= '0;
            ridx_q  <= '0;
            rerr_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (ar_hs) begin
                rid_q   <= arid_i;
                rlen_q  <= arlen_i;
                rbeat_q <= '0;
                rcnt_q  <= 4'(RD_LATENCY - 1);
                ridx_q  <= araddr_i[IW+1:2];
                rerr_q  <= !burst_legal(araddr_i, arlen_i, arsize_i, arburst_i);
            end
            if (rstate_q == R_WAIT && rcnt_q != 4'd0) rcnt_q <= rcnt_q - 4'd1;
            if (r_hs && rbeat_q != rlen_q) rbeat_q <= rbeat_q + 4'd1;
            if (rd_load) begin
                rdata_q <= rerr_q ? 32'd0 : mem[ridx_q];
                ridx_q  <= ridx_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: one task per scenario, inline checks.
module tb_axi_slave_mem;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  awid, wid, arid, bid_o, rid_o;
    logic [31:0] awaddr, araddr, wdata, rdata_o;
    logic [3:0]  awlen, arlen, wstrb;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp_o, rresp_o;
    logic        awvalid, wlast, wvalid, bready, arvalid, rready;
    logic        awready_o, wready_o, bvalid_o, arready_o, rlast_o, rvalid_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] rd_d  [16];
    logic [1:0]  rd_rs [16];
    logic [3:0]  rd_id [16];
    logic [15:0] rd_last;

    axi_slave_mem #(.ADDR_LG2(10), .RD_LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .awid_i(awid), .awaddr_i(awaddr), .awlen_i(awlen), .awsize_i(awsize),
        .awburst_i(awburst), .awvalid_i(awvalid), .awready_o(awready_o),
        .wid_i(wid), .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast),
        .wvalid_i(wvalid), .wready_o(wready_o),
        .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready),
        .arid_i(arid), .araddr_i(araddr), .arlen_i(arlen), .arsize_i(arsize),
        .arburst_i(arburst), .arvalid_i(arvalid), .arready_o(arready_o),
        .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
        .rvalid_o(rvalid_o), .rready_i(rready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus drivers (no checking) ----------------
    task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] sz, output bit to);
        awid = id; awaddr = addr; awlen = len; awsize = sz; awburst = 2'b01; awvalid = 1'b1;
        to = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (awready_o) begin to = 1'b0; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        awvalid = 1'b0;
    endtask

    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] sz, output bit to);
        arid = id; araddr = addr; arlen = len; arsize = sz; arburst = 2'b01; arvalid = 1'b1;
        to = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (arready_o) begin to = 1'b0; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic do_w(input logic [3:0] id, input int n, input logic [31:0] base,
                        input logic [3:0] strb, input bit badlast, output bit to);
        to = 1'b0;
        for (int i = 0; i < n; i++) begin
            wid = id; wdata = base + 32'(i); wstrb = strb;
            wlast = badlast ? 1'b0 : (i == n - 1);
            wvalid = 1'b1;
            for (int k = 0; k < 50 && !wready_o; k++) begin @(posedge clk); #1; end
            if (!wready_o) to = 1'b1;
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic wait_b(output logic [3:0] id, output logic [1:0] resp, output bit to);
        bready = 1'b1; to = 1'b1; id = '0; resp = '0;
        for (int n = 0; n < 50; n++) begin
            if (bvalid_o) begin to = 1'b0; id = bid_o; resp = bresp_o; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    // Accepts n R beats into rd_* ; toggle alternates rready 1/0.
    task automatic rd_collect(input int n, input bit toggle, output bit held_ok, output bit to);
        int got = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        logic [31:0] stall_d = '0;
        held_ok = 1'b1; to = 1'b0; rd_last = '0;
        while (got < n) begin
            if (cyc > 200) begin to = 1'b1; break; end
            rready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (rvalid_o) begin
                if (stalled && rdata_o !== stall_d) held_ok = 1'b0;
                if (rready) begin
                    rd_d[got] = rdata_o; rd_rs[got] = rresp_o;
                    rd_id[got] = rid_o; rd_last[got] = rlast_o;
                    got++; stalled = 1'b0;
                end else begin
                    stalled = 1'b1; stall_d = rdata_o;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        rready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if ({awready_o, arready_o} !== 2'b11) begin bad++; $display("FAIL reset_ready got=%b exp=11", {awready_o, arready_o}); end
        total++; if ({wready_o, bvalid_o, rvalid_o, rlast_o} !== 4'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0000", {wready_o, bvalid_o, rvalid_o, rlast_o}); end
        total++; if ({bid_o, rid_o, bresp_o, rresp_o} !== 12'h0) begin bad++; $display("FAIL reset_ids got=%h exp=000", {bid_o, rid_o, bresp_o, rresp_o}); end
        total++; if (rdata_o !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata_o); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single;
        bit to, held, anyto = 1'b0;
        logic [3:0] id; logic [1:0] rs;
        do_aw(4'd2, 32'h100, 4'd0, 3'b010, to); anyto |= to;
        do_w(4'd2, 1, 32'hDEADBEEF, 4'hF, 1'b0, to); anyto |= to;
        wait_b(id, rs, to); anyto |= to;
        total++; if ({id, rs} !== {4'd2, 2'b00}) begin bad++; $display("FAIL single_b got=%h/%b exp=2/00", id, rs); end
        do_ar(4'd1, 32'h100, 4'd0, 3'b010, to); anyto |= to;
        total++; if (rvalid_o !== 1'b0) begin bad++; $display("FAIL lat_c0 got=%b exp=0", rvalid_o); end
        @(posedge clk); #1;
        total++; if (rvalid_o !== 1'b0) begin bad++; $display("FAIL lat_c1 got=%b exp=0", rvalid_o); end
        @(posedge clk); #1;
        total++; if (rvalid_o !== 1'b1) begin bad++; $display("FAIL lat_c2 got=%b exp=1", rvalid_o); end
        rd_collect(1, 1'b0, held, to); anyto |= to;
        total++; if (rd_d[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL single_data got=%h exp=deadbeef", rd_d[0]); end
        total++; if ({rd_id[0], rd_rs[0], rd_last[0]} !== {4'd1, 2'b00, 1'b1}) begin bad++; $display("FAIL single_r got=%h/%b/%b exp=1/00/1", rd_id[0], rd_rs[0], rd_last[0]); end
        total++; if (anyto !== 1'b0) begin bad++; $display("FAIL single_timeout got=%b exp=0", anyto); end
    endtask

    task automatic test_burst16;
        bit to, held, anyto = 1'b0;
        logic [3:0] id; logic [1:0] rs;
        do_aw(4'd3, 32'h200, 4'd15, 3'b010, to); anyto |= to;
        do_w(4'd3, 16, 32'h0, 4'hF, 1'b0, to); anyto |= to;
        wait_b(id, rs, to); anyto |= to;
        total++; if ({id, rs} !== {4'd3, 2'b00}) begin bad++; $display("FAIL b16_b got=%h/%b exp=3/00", id, rs); end
        do_ar(4'd4, 32'h200, 4'd15, 3'b010, to); anyto |= to;
        rd_collect(16, 1'b1, held, to); anyto |= to;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (rd_d[i] !== 32'(i) || rd_id[i] !== 4'd4 || rd_rs[i] !== 2'b00) begin
                bad++; $display("FAIL b16_beat%0d got=%h/%h/%b exp=%h/4/00", i, rd_d[i], rd_id[i], rd_rs[i], i);
            end
        end
        total++; if (rd_last !== 16'h8000) begin bad++; $display("FAIL b16_rlast got=%h exp=8000", rd_last); end
        total++; if (held !== 1'b1) begin bad++; $display("FAIL b16_hold got=%b exp=1", held); end
        total++; if (rvalid_o !== 1'b0) begin bad++; $display("FAIL b16_end got=%b exp=0", rvalid_o); end
        total++; if (anyto !== 1'b0) begin bad++; $display("FAIL b16_timeout got=%b exp=0", anyto); end
    endtask

    task automatic test_strobe;
        bit to, held, anyto = 1'b0;
        logic [3:0] id; logic [1:0] rs;
        do_aw(4'd0, 32'h180, 4'd0, 3'b010, to); anyto |= to;
        do_w(4'd0, 1, 32'hFFFFFFFF, 4'hF, 1'b0, to); anyto |= to;
        wait_b(id, rs, to); anyto |= to;
        do_aw(4'd0, 32'h180, 4'd0, 3'b010, to); anyto |= to;
        do_w(4'd0, 1, 32'h12345678, 4'b0101, 1'b0, to); anyto |= to;
        wait_b(id, rs, to); anyto |= to;
        do_ar(4'd0, 32'h180, 4'd0, 3'b010, to); anyto |= to;
        rd_collect(1, 1'b0, held, to); anyto |= to;
        total++; if (rd_d[0] !== 32'hFF34FF78) begin bad++; $display("FAIL strobe_data got=%h exp=ff34ff78", rd_d[0]); end
        total++; if (anyto !== 1'b0) begin bad++; $display("FAIL strobe_timeout got=%b exp=0", anyto); end
    endtask

    task automatic test_illegal;
        bit to, held, anyto = 1'b0;
        logic [3:0] id; logic [1:0] rs;
        do_ar(4'd7, 32'h0FFC, 4'd1, 3'b010, to); anyto |= to;
        rd_collect(2, 1'b0, held, to); anyto |= to;
        total++; if ({rd_rs[0], rd_rs[1]} !== 4'b1010) begin bad++; $display("FAIL ill_rresp got=%b exp=1010", {rd_rs[0], rd_rs[1]}); end
        total++; if ((rd_d[0] | rd_d[1]) !== 32'h0) begin bad++; $display("FAIL ill_rdata got=%h/%h exp=0/0", rd_d[0], rd_d[1]); end
        total++; if (rd_last[1:0] !== 2'b10) begin bad++; $display("FAIL ill_rlast got=%b exp=10", rd_last[1:0]); end
        do_aw(4'd0, 32'h300, 4'd0, 3'b010, to); anyto |= to;
        do_w(4'd0, 1, 32'hAAAA5555, 4'hF, 1'b0, to); anyto |= to;
        wait_b(id, rs, to); anyto |= to;
        do_aw(4'd8, 32'h300, 4'd0, 3'b001, to); anyto |= to;
        do_w(4'd8, 1, 32'h11111111, 4'hF, 1'b0, to); anyto |= to;
        wait_b(id, rs, to); anyto |= to;
        total++; if ({id, rs} !== {4'd8, 2'b10}) begin bad++; $display("FAIL ill_b got=%h/%b exp=8/10", id, rs); end
        do_ar(4'd0, 32'h300, 4'd0, 3'b010, to); anyto |= to;
        rd_collect(1, 1'b0, held, to); anyto |= to;
        total++; if (rd_d[0] !== 32'hAAAA5555) begin bad++; $display("FAIL ill_nowrite got=%h exp=aaaa5555", rd_d[0]); end
        total++; if (anyto !== 1'b0) begin bad++; $display("FAIL ill_timeout got=%b exp=0", anyto); end
    endtask

    task automatic test_wlast_err;
        bit to, anyto = 1'b0;
        logic [3:0] id; logic [1:0] rs;
        do_aw(4'd9, 32'h340, 4'd1, 3'b010, to); anyto |= to;
        do_w(4'd9, 2, 32'h0, 4'hF, 1'b1, to); anyto |= to;
        wait_b(id, rs, to); anyto |= to;
        total++; if ({id, rs} !== {4'd9, 2'b10}) begin bad++; $display("FAIL wlast_b got=%h/%b exp=9/10", id, rs); end
        do_aw(4'd10, 32'h348, 4'd0, 3'b010, to); anyto |= to;
        do_w(4'd11, 1, 32'h0, 4'hF, 1'b0, to); anyto |= to;
        wait_b(id, rs, to); anyto |= to;
        total++; if ({id, rs} !== {4'd10, 2'b10}) begin bad++; $display("FAIL wid_b got=%h/%b exp=a/10", id, rs); end
        total++; if (anyto !== 1'b0) begin bad++; $display("FAIL werr_timeout got=%b exp=0", anyto); end
    endtask

    task automatic test_concurrent;
        bit t1, t2, t3, t4, t5, t6, h1, h2, anyto = 1'b0;
        logic [3:0] id, cid; logic [1:0] rs, crs;
        // seed the overlap word with a known old value
        do_aw(4'd0, 32'h500, 4'd0, 3'b010, t1); anyto |= t1;
        do_w(4'd0, 1, 32'h0BAD0BAD, 4'hF, 1'b0, t1); anyto |= t1;
        wait_b(id, rs, t1); anyto |= t1;
        fork
            begin
                do_aw(4'd5, 32'h400, 4'd3, 3'b010, t1);
                do_w(4'd5, 4, 32'h100000A0, 4'hF, 1'b0, t2);
                wait_b(cid, crs, t3);
            end
            begin
                do_ar(4'd6, 32'h200, 4'd3, 3'b010, t4);
                rd_collect(4, 1'b0, h1, t5);
            end
        join
        anyto |= t1 | t2 | t3 | t4 | t5;
        total++; if ({cid, crs} !== {4'd5, 2'b00}) begin bad++; $display("FAIL conc_b got=%h/%b exp=5/00", cid, crs); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rd_d[i] !== 32'(i) || rd_id[i] !== 4'd6) begin bad++; $display("FAIL conc_r%0d got=%h/%h exp=%h/6", i, rd_d[i], rd_id[i], i); end
        end
        do_ar(4'd0, 32'h400, 4'd3, 3'b010, t1); anyto |= t1;
        rd_collect(4, 1'b0, h1, t1); anyto |= t1;
        total++; if ({rd_d[0], rd_d[3]} !== {32'h100000A0, 32'h100000A3}) begin bad++; $display("FAIL conc_wdata got=%h/%h exp=100000a0/100000a3", rd_d[0], rd_d[3]); end
        // read data is fetched on the same edge as the W beat lands
        fork
            begin
                do_ar(4'd12, 32'h500, 4'd0, 3'b010, t4);
                rd_collect(1, 1'b0, h2, t5);
            end
            begin
                do_aw(4'd13, 32'h500, 4'd0, 3'b010, t1);
                @(posedge clk); #1;
                do_w(4'd13, 1, 32'h600D600D, 4'hF, 1'b0, t2);
                wait_b(cid, crs, t6);
            end
        join
        anyto |= t1 | t2 | t4 | t5 | t6;
        total++; if (rd_d[0] !== 32'h0BAD0BAD) begin bad++; $display("FAIL overlap_old got=%h exp=0bad0bad", rd_d[0]); end
        do_ar(4'd0, 32'h500, 4'd0, 3'b010, t1); anyto |= t1;
        rd_collect(1, 1'b0, h1, t1); anyto |= t1;
        total++; if (rd_d[0] !== 32'h600D600D) begin bad++; $display("FAIL overlap_new got=%h exp=600d600d", rd_d[0]); end
        total++; if (anyto !== 1'b0) begin bad++; $display("FAIL conc_timeout got=%b exp=0", anyto); end
    endtask

    task automatic test_reset_mid;
        bit to, held, anyto = 1'b0;
        do_ar(4'd14, 32'h200, 4'd7, 3'b010, to); anyto |= to;
        rd_collect(3, 1'b0, held, to); anyto |= to;
        total++; if ({rvalid_o, rdata_o} !== {1'b1, 32'd3}) begin bad++; $display("FAIL mid_beat3 got=%b/%h exp=1/3", rvalid_o, rdata_o); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        total++; if ({rvalid_o, arready_o} !== 2'b01) begin bad++; $display("FAIL mid_reset got=%b exp=01", {rvalid_o, arready_o}); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_ar(4'd15, 32'h210, 4'd0, 3'b010, to); anyto |= to;
        rd_collect(1, 1'b0, held, to); anyto |= to;
        total++; if ({rd_d[0], rd_id[0], rd_last[0]} !== {32'd4, 4'd15, 1'b1}) begin bad++; $display("FAIL mid_after got=%h/%h/%b exp=4/f/1", rd_d[0], rd_id[0], rd_last[0]); end
        total++; if (anyto !== 1'b0) begin bad++; $display("FAIL mid_timeout got=%b exp=0", anyto); end
    endtask

    initial begin
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0; rst_n = 1'b0;
        test_reset();
        test_single();
        test_burst16();
        test_strobe();
        test_illegal();
        test_wlast_err();
        test_concurrent();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
